// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned NREQ_DEF   = 3;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IDX_W      = $clog2(NREQ_DEF);

  // Widest index needed for NREQ up to 8; the pending-read record is sized for that
  localparam int unsigned IDX_MAX_W  = 3;
  // Lock counter holds values up to MAX_LOCK (at most 15)
  localparam int unsigned CNT_W      = 4;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } rd_pend_t;

  // Index width for an overridden requester count (never below one bit)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first set request at or above the pointer, wrapping modulo N.
module rr_pick
  #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
  ) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
  );

  logic [IW-1:0] w_pos;

  // Scan N positions starting at the pointer; the first hit wins
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = IW'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_pos]) begin
        o_onehot[w_pos] = 1'b1;
        o_idx           = w_pos;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NREQ
// requesters, with a bounded lock for back-to-back accesses by one owner.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
  #(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_LOCK = 4
  ) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]            perf_busy,
    output logic [15:0]            perf_conflict
`endif
  );

  localparam int unsigned IW = idx_w(NREQ);

  logic [IW-1:0]    r_rr_ptr;
  logic             r_own_valid;
  logic [IW-1:0]    r_own_idx;
  logic [CNT_W-1:0] r_lock_cnt;
  rd_pend_t         r_rd_pend;

  logic [NREQ-1:0]  w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_own_ok;
  logic [NREQ-1:0]  w_own_oh;
  logic             w_gnt_any;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_same_owner;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Grant selection: a locked owner under its limit beats round-robin
  always_comb begin
    w_own_ok  = r_own_valid && req[r_own_idx] && (r_lock_cnt < CNT_W'(MAX_LOCK));
    w_own_oh  = '0;
    w_own_oh[r_own_idx] = 1'b1;
    w_gnt_any = RST && (w_own_ok || w_pick_any);
    w_gnt_idx = w_own_ok ? r_own_idx : w_pick_idx;
    if (!RST) begin
      gnt = '0;
    end else if (w_own_ok) begin
      gnt = w_own_oh;
    end else begin
      gnt = w_pick_oh;
    end
    w_same_owner = r_own_valid && (r_own_idx == w_gnt_idx);
  end

  // Memory port mux from the one-hot grant
  always_comb begin
    mem_en    = w_gnt_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration state: pointer, lock ownership and the outstanding read
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rr_ptr    <= '0;
      r_own_valid <= 1'b0;
      r_own_idx   <= '0;
      r_lock_cnt  <= '0;
      r_rd_pend   <= '0;
    end else begin
      if (w_gnt_any) begin
        r_rr_ptr <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        if (lock[w_gnt_idx]) begin
          r_own_valid <= 1'b1;
          r_own_idx   <= w_gnt_idx;
          // A re-grant after hitting the limit starts a fresh lock run
          r_lock_cnt  <= (w_same_owner && (r_lock_cnt < CNT_W'(MAX_LOCK))) ?
                         r_lock_cnt + 1'b1 : CNT_W'(1);
        end else begin
          r_own_valid <= 1'b0;
          r_lock_cnt  <= '0;
        end
      end else begin
        // No grant means no requests, so any owner has dropped req
        r_own_valid <= 1'b0;
        r_lock_cnt  <= '0;
      end
      r_rd_pend.valid <= w_gnt_any && !mem_we;
      r_rd_pend.idx   <= IDX_MAX_W'(w_gnt_idx);
    end
  end

  // Read response: one-cycle pulse to the requester that issued the read
  always_comb begin
    rdata = mem_rdata;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid[i] = RST && r_rd_pend.valid && (r_rd_pend.idx == IDX_MAX_W'(i));
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_perf_busy;
  logic [15:0] r_perf_conflict;
  logic        w_multi_req;

  // Two or more simultaneous requests count as a conflict
  always_comb begin
    w_multi_req = ($countones(req) > 1);
  end

  // Saturating utilisation and contention counters
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_perf_busy     <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (mem_en && (r_perf_busy != 16'hFFFF)) begin
        r_perf_busy <= r_perf_busy + 16'd1;
      end
      if (w_multi_req && (r_perf_conflict != 16'hFFFF)) begin
        r_perf_conflict <= r_perf_conflict + 16'd1;
      end
    end
  end

  assign perf_busy     = r_perf_busy;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grant, read
// response and counter values; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [2:0]  req  = '0;
  logic [2:0]  lock = '0;
  logic [2:0]  we   = '0;
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_busy;
  logic [15:0] perf_conflict;
`endif

  logic [15:0] a  [3];
  logic [15:0] d  [3];
  logic [15:0] na [3];
  logic [15:0] nd [3];
  logic [15:0] mem [256];

  assign addr  = {a[2], a[1], a[0]};
  assign wdata = {d[2], d[1], d[0]};

  mem_port_arbiter #(
    .NREQ     (3),
    .ADDR_W   (16),
    .DATA_W   (16),
    .MAX_LOCK (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_busy     (perf_busy),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 CLK = ~CLK;

  // Synchronous memory macro model with one-cycle read latency
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  gnt;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
  } exp_g_t;

  typedef struct {
    int          cyc;
    logic [2:0]  rv;
    logic [15:0] data;
  } exp_r_t;

  typedef struct {
    int          cyc;
    logic [15:0] busy;
    logic [15:0] conf;
  } exp_p_t;

  exp_g_t q_g[$];
  exp_r_t q_r[$];
  exp_p_t q_p[$];
  exp_g_t mg;
  exp_r_t mr;
  exp_p_t mp;

  int checks = 0;
  int errors = 0;

  // Monitor: every scoreboard comparison happens here
  always @(negedge CLK) begin
    if (q_g.size() > 0) begin
      mg = q_g.pop_front();
      checks++;
      if (gnt !== mg.gnt || mem_en !== (|mg.gnt) || mem_we !== mg.we ||
          ((|mg.gnt) && mem_addr !== mg.addr) || (mg.we && mem_wdata !== mg.wd)) begin
        errors++;
        $display("FAIL grant cyc %0d: got gnt=%b en=%b we=%b addr=%h wd=%h, want gnt=%b we=%b addr=%h wd=%h",
                 cyc, gnt, mem_en, mem_we, mem_addr, mem_wdata, mg.gnt, mg.we, mg.addr, mg.wd);
      end
    end
    while (q_r.size() > 0 && q_r[0].cyc < cyc) begin
      mr = q_r.pop_front();
      checks++;
      errors++;
      $display("FAIL rvalid_missing cyc %0d: got none, want rvalid=%b rdata=%h", mr.cyc, mr.rv,
               mr.data);
    end
    if (q_r.size() > 0 && q_r[0].cyc == cyc) begin
      mr = q_r.pop_front();
      checks++;
      if (rvalid !== mr.rv || rdata !== mr.data) begin
        errors++;
        $display("FAIL read cyc %0d: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, mr.rv, mr.data);
      end
    end else if (rvalid !== 3'b000) begin
      checks++;
      errors++;
      $display("FAIL rvalid_extra cyc %0d: got rvalid=%b, want 000", cyc, rvalid);
    end
`ifdef MEM_ARB_PERF_EN
    if (q_p.size() > 0 && q_p[0].cyc == cyc) begin
      mp = q_p.pop_front();
      checks++;
      if (perf_busy !== mp.busy || perf_conflict !== mp.conf) begin
        errors++;
        $display("FAIL perf cyc %0d: got busy=%0d conflict=%0d, want busy=%0d conflict=%0d",
                 cyc, perf_busy, perf_conflict, mp.busy, mp.conf);
      end
    end
`endif
  end

  // One cycle of stimulus plus its hand-computed expectations
  task automatic drive(input logic rst, input logic [2:0] rq, input logic [2:0] lk,
                       input logic [2:0] w, input logic [2:0] eg, input bit rd_exp,
                       input logic [15:0] erd);
    exp_g_t e;
    exp_r_t r;
    int     gi;
    @(posedge CLK);
    #1;
    RST  = rst;
    req  = rq;
    lock = lk;
    we   = w;
    a    = na;
    d    = nd;
    gi   = eg[2] ? 2 : (eg[1] ? 1 : 0);
    e.gnt  = eg;
    e.we   = |(eg & w);
    e.addr = na[gi];
    e.wd   = nd[gi];
    q_g.push_back(e);
    if (rd_exp) begin
      r.cyc  = cyc + 1;
      r.rv   = eg;
      r.data = erd;
      q_r.push_back(r);
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic expect_perf(input logic [15:0] b, input logic [15:0] c);
    exp_p_t p;
    p.cyc  = cyc;
    p.busy = b;
    p.conf = c;
    q_p.push_back(p);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hA001;
    mem[8'h20] = 16'hB002;
    mem[8'h30] = 16'hC003;
    na = '{16'h0010, 16'h0020, 16'h0030};
    nd = '{16'h0000, 16'h0000, 16'h0000};
    a  = na;
    d  = nd;

    // Reset held with all requesting: nothing granted
    repeat (2) drive(1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);

    // Plain round-robin reads
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b001, 1'b1, 16'hA001);
      drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b010, 1'b1, 16'hB002);
      drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b100, 1'b1, 16'hC003);
    end

    // Move the pointer to 1, then requester 1 locks against requester 0
    drive(1'b1, 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 16'hA001);
    repeat (4) drive(1'b1, 3'b011, 3'b010, 3'b000, 3'b010, 1'b1, 16'hB002);
    drive(1'b1, 3'b011, 3'b010, 3'b000, 3'b001, 1'b1, 16'hA001);
    drive(1'b1, 3'b011, 3'b010, 3'b000, 3'b010, 1'b1, 16'hB002);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);

    // Requester 2 writes, requester 0 reads it back
    na[2] = 16'h0005;
    nd[2] = 16'h13B0;
    na[0] = 16'h0005;
    drive(1'b1, 3'b100, 3'b000, 3'b100, 3'b100, 1'b0, 16'h0);
    drive(1'b1, 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 16'h13B0);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);

    // Read to requester 1 followed by reset: response suppressed, pointer back to 0
    drive(1'b1, 3'b010, 3'b000, 3'b000, 3'b010, 1'b0, 16'h0);
    drive(1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);
    drive(1'b1, 3'b111, 3'b000, 3'b000, 3'b001, 1'b1, 16'h13B0);
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);

`ifdef MEM_ARB_PERF_EN
    drive(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) drive(1'b1, 3'b011, 3'b000, 3'b000, 3'b001, 1'b1, 16'h13B0);
      else            drive(1'b1, 3'b011, 3'b000, 3'b000, 3'b010, 1'b1, 16'hB002);
    end
    drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);
    expect_perf(16'd10, 16'd10);
    repeat (5) drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);
    expect_perf(16'd10, 16'd10);
`endif

    // Drain: stale read expectations are flagged by the monitor as cycles pass
    repeat (3) drive(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0);
    @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
